// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, default widths
// and the largest legal EXEC settle count.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 3;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_LOAD_A_ENC = 3'd1;
  localparam logic [2:0] ST_LOAD_B_ENC = 3'd2;
  localparam logic [2:0] ST_EXEC_ENC   = 3'd3;
  localparam logic [2:0] ST_DRIVE_ENC  = 3'd4;
  localparam logic [2:0] ST_RESP_ENC   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE_ENC,
    LOAD_A = ST_LOAD_A_ENC,
    LOAD_B = ST_LOAD_B_ENC,
    EXEC   = ST_EXEC_ENC,
    DRIVE  = ST_DRIVE_ENC,
    RESP   = ST_RESP_ENC
  } state_t;

  // The ALU sees the latched opcode only while the datapath is being worked.
  function automatic logic drives_opcode(input state_t st);
    logic result;
    case (st)
      LOAD_A, LOAD_B, EXEC, DRIVE: result = 1'b1;
      default:                     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Control FSM that runs one ALU operation over the R0/R1/R2 datapath and
// returns the tri-stated result over a valid/ready response handshake.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] bus_drive,
  output logic              bus_oe,
  output logic [OP_W-1:0]   opCode,
  output logic              ALUin1,
  output logic              ALUin2,
  output logic              ALU_outlach,
  output logic              ALU_outEN,
  input  logic [DATA_W-1:0] bus_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  // SETTLE is limited to SETTLE_MAX so the 4-bit counter never wraps.
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  state_t              state_r, state_s;
  logic [OP_W-1:0]     op_r, op_s;
  logic [DATA_W-1:0]   a_r, a_s;
  logic [DATA_W-1:0]   b_r, b_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_s;

  logic                cmd_ready_r, cmd_ready_s;
  logic [DATA_W-1:0]   bus_drive_r, bus_drive_s;
  logic                bus_oe_r, bus_oe_s;
  logic [OP_W-1:0]     opcode_r, opcode_s;
  logic                alu_in1_r, alu_in1_s;
  logic                alu_in2_r, alu_in2_s;
  logic                alu_outlach_r, alu_outlach_s;
  logic                alu_outen_r, alu_outen_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic                busy_r, busy_s;

  // Next state plus command, counter and result register updates.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    a_s        = a_r;
    b_s        = b_r;
    cnt_s      = cnt_r;
    rsp_data_s = rsp_data_r;
    case (state_r)
      IDLE: begin
        // cmd_ready_r gates the accept so the first cycle after reset is idle.
        if (cmd_valid && cmd_ready_r) begin
          state_s = LOAD_A;
          op_s    = cmd_op;
          a_s     = cmd_a;
          b_s     = cmd_b;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_A: state_s = LOAD_B;
      LOAD_B: begin
        state_s = EXEC;
        cnt_s   = {CNT_W{1'b0}};
      end
      EXEC: begin
        if (cnt_r == SETTLE_CNT) begin
          state_s = DRIVE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = EXEC;
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DRIVE: begin
        state_s    = RESP;
        rsp_data_s = bus_out;
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    cmd_ready_s   = 1'b0;
    bus_drive_s   = {DATA_W{1'b0}};
    bus_oe_s      = 1'b0;
    alu_in1_s     = 1'b0;
    alu_in2_s     = 1'b0;
    alu_outlach_s = 1'b0;
    alu_outen_s   = 1'b0;
    rsp_valid_s   = 1'b0;
    case (state_s)
      IDLE:   cmd_ready_s = 1'b1;
      LOAD_A: begin
        bus_drive_s = a_s;
        bus_oe_s    = 1'b1;
        alu_in1_s   = 1'b1;
      end
      LOAD_B: begin
        bus_drive_s = b_s;
        bus_oe_s    = 1'b1;
        alu_in2_s   = 1'b1;
      end
      EXEC:    alu_outlach_s = (cnt_s == SETTLE_CNT);
      DRIVE:   alu_outen_s   = 1'b1;
      RESP:    rsp_valid_s   = 1'b1;
      default: cmd_ready_s   = 1'b0;
    endcase
    if (drives_opcode(state_s)) begin
      opcode_s = op_s;
    end else begin
      opcode_s = {OP_W{1'b0}};
    end
    busy_s = (state_s != IDLE);
  end

  // State, command fields, counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= {OP_W{1'b0}};
      a_r        <= {DATA_W{1'b0}};
      b_r        <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      rsp_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      a_r        <= a_s;
      b_r        <= b_s;
      cnt_r      <= cnt_s;
      rsp_data_r <= rsp_data_s;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r   <= 1'b0;
      bus_drive_r   <= {DATA_W{1'b0}};
      bus_oe_r      <= 1'b0;
      opcode_r      <= {OP_W{1'b0}};
      alu_in1_r     <= 1'b0;
      alu_in2_r     <= 1'b0;
      alu_outlach_r <= 1'b0;
      alu_outen_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      cmd_ready_r   <= cmd_ready_s;
      bus_drive_r   <= bus_drive_s;
      bus_oe_r      <= bus_oe_s;
      opcode_r      <= opcode_s;
      alu_in1_r     <= alu_in1_s;
      alu_in2_r     <= alu_in2_s;
      alu_outlach_r <= alu_outlach_s;
      alu_outen_r   <= alu_outen_s;
      rsp_valid_r   <= rsp_valid_s;
      busy_r        <= busy_s;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign bus_drive   = bus_drive_r;
  assign bus_oe      = bus_oe_r;
  assign opCode      = opcode_r;
  assign ALUin1      = alu_in1_r;
  assign ALUin2      = alu_in2_r;
  assign ALU_outlach = alu_outlach_r;
  assign ALU_outEN   = alu_outen_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: two sequencers (SETTLE=0 and SETTLE=3), each beside a
// small behavioural R0/R1/R2 datapath, checked cycle by cycle.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cv0, cv3;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        rsp_ready;

  logic        cr0, oe0, in1_0, in2_0, lat0, en0, rv0, busy0;
  logic [15:0] bd0, rd0, bus_out0;
  logic [2:0]  opc0;
  logic        cr3, oe3, in1_3, in2_3, lat3, en3, rv3, busy3;
  logic [15:0] bd3, rd3, bus_out3;
  logic [2:0]  opc3;

  logic        ovr_en;
  logic [15:0] ovr_val;
  logic        sel;

  int vectors     = 0;
  int miscompares = 0;

  alu_sequencer #(.DATA_W(16), .OP_W(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(cr0), .cmd_op(op),
    .cmd_a(a), .cmd_b(b), .bus_drive(bd0), .bus_oe(oe0), .opCode(opc0),
    .ALUin1(in1_0), .ALUin2(in2_0), .ALU_outlach(lat0), .ALU_outEN(en0),
    .bus_out(bus_out0), .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_data(rd0), .busy(busy0));

  alu_sequencer #(.DATA_W(16), .OP_W(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cv3), .cmd_ready(cr3), .cmd_op(op),
    .cmd_a(a), .cmd_b(b), .bus_drive(bd3), .bus_oe(oe3), .opCode(opc3),
    .ALUin1(in1_3), .ALUin2(in2_3), .ALU_outlach(lat3), .ALU_outEN(en3),
    .bus_out(bus_out3), .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_data(rd3), .busy(busy3));

  function automatic logic [15:0] alu_ref(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ~x;
      3'd6: return x << 1;
      default: return y;
    endcase
  endfunction

  // Behavioural datapath beside each sequencer; bus_out shows junk unless enabled.
  logic [15:0] r0_0, r1_0, r2_0, r0_3, r1_3, r2_3;
  always @(posedge clk) begin
    if (in1_0) r0_0 <= bd0;
    if (in2_0) r1_0 <= bd0;
    if (lat0)  r2_0 <= alu_ref(opc0, r0_0, r1_0);
    if (in1_3) r0_3 <= bd3;
    if (in2_3) r1_3 <= bd3;
    if (lat3)  r2_3 <= alu_ref(opc3, r0_3, r1_3);
  end
  assign bus_out0 = en0 ? (ovr_en ? ovr_val : r2_0) : 16'hA5A5;
  assign bus_out3 = en3 ? (ovr_en ? ovr_val : r2_3) : 16'hA5A5;

  // Selected-DUT view used by the shared command task.
  logic        s_cr, s_oe, s_in1, s_in2, s_lat, s_en, s_rv, s_busy;
  logic [15:0] s_bd, s_rd;
  logic [2:0]  s_opc;
  assign s_cr   = sel ? cr3   : cr0;
  assign s_oe   = sel ? oe3   : oe0;
  assign s_in1  = sel ? in1_3 : in1_0;
  assign s_in2  = sel ? in2_3 : in2_0;
  assign s_lat  = sel ? lat3  : lat0;
  assign s_en   = sel ? en3   : en0;
  assign s_rv   = sel ? rv3   : rv0;
  assign s_busy = sel ? busy3 : busy0;
  assign s_bd   = sel ? bd3   : bd0;
  assign s_rd   = sel ? rd3   : rd0;
  assign s_opc  = sel ? opc3  : opc0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("onehot_s0", 32'($countones({in1_0, in2_0, lat0, en0}) <= 1), 32'd1);
    check("onehot_s3", 32'($countones({in1_3, in2_3, lat3, en3}) <= 1), 32'd1);
    check("oe_en_s0", 32'(oe0 & en0), 32'd0);
    check("oe_en_s3", 32'(oe3 & en3), 32'd0);
    check("drive_off_s0", oe0 ? 32'd0 : 32'(bd0), 32'd0);
    check("drive_off_s3", oe3 ? 32'd0 : 32'(bd3), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({s_cr, s_oe, s_opc, s_in1, s_in2, s_lat, s_en, s_rv, s_busy}), 32'd0);
    check({tag, "_bd"}, 32'(s_bd), 32'd0);
    check({tag, "_rd"}, 32'(s_rd), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (s_cr !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_wait", 32'(s_cr), 32'd1);
  endtask

  task automatic run_cmd(input logic which, input logic [2:0] o, input logic [15:0] xa,
                         input logic [15:0] xb, input int hold, input logic use_ovr,
                         input logic [15:0] ov);
    int s;
    logic [15:0] exp;
    s       = which ? 3 : 0;
    sel     = which;
    ovr_en  = use_ovr;
    ovr_val = ov;
    exp     = use_ovr ? ov : alu_ref(o, xa, xb);
    wait_ready();
    op = o; a = xa; b = xb; rsp_ready = 1'b0;
    if (which) cv3 = 1'b1; else cv0 = 1'b1;
    step();
    cv0 = 1'b0; cv3 = 1'b0;
    check("c1_in1", 32'(s_in1), 32'd1);
    check("c1_drive", 32'(s_bd), 32'(xa));
    check("c1_oe", 32'(s_oe), 32'd1);
    check("c1_op", 32'(s_opc), 32'(o));
    check("c1_ready", 32'(s_cr), 32'd0);
    step();
    check("c2_in2", 32'(s_in2), 32'd1);
    check("c2_drive", 32'(s_bd), 32'(xb));
    check("c2_op", 32'(s_opc), 32'(o));
    for (int k = 0; k <= s; k++) begin
      step();
      check("exec_latch", 32'(s_lat), 32'(k == s));
      check("exec_op", 32'(s_opc), 32'(o));
      check("exec_oe", 32'(s_oe), 32'd0);
      check("exec_busy", 32'(s_busy), 32'd1);
    end
    step();
    check("drv_en", 32'(s_en), 32'd1);
    check("drv_op", 32'(s_opc), 32'(o));
    check("drv_valid", 32'(s_rv), 32'd0);
    step();
    check("rsp_valid", 32'(s_rv), 32'd1);
    check("rsp_data", 32'(s_rd), 32'(exp));
    check("rsp_op", 32'(s_opc), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("bp_valid", 32'(s_rv), 32'd1);
      check("bp_data", 32'(s_rd), 32'(exp));
      check("bp_ready", 32'(s_cr), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("idle_valid", 32'(s_rv), 32'd0);
    check("idle_ready", 32'(s_cr), 32'd1);
    check("idle_busy", 32'(s_busy), 32'd0);
    check("idle_data_kept", 32'(s_rd), 32'(exp));
  endtask

  initial begin
    logic [15:0] e1, e2, a2;
    rst = 1'b1; cv0 = 1'b0; cv3 = 1'b0; rsp_ready = 1'b0;
    op = 3'd0; a = 16'd0; b = 16'd0;
    ovr_en = 1'b0; ovr_val = 16'd0; sel = 1'b0;

    // Reset state and release.
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 check_zero("rst_s0");
    sel = 1'b1; #1 check_zero("rst_s3");
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_ready0", 32'(cr0), 32'd1);
    check("post_rst_ready3", 32'(cr3), 32'd1);

    // Directed single operations, SETTLE=0 and SETTLE=3.
    run_cmd(1'b0, 3'b010, 16'h1234, 16'h0F0F, 0, 1'b1, 16'hBEEF);
    run_cmd(1'b1, 3'b010, 16'h1234, 16'h0F0F, 0, 1'b1, 16'hBEEF);

    // Backpressure for 10 cycles on both.
    run_cmd(1'b0, 3'd1, 16'h4000, 16'h0123, 10, 1'b0, 16'd0);
    run_cmd(1'b1, 3'd4, 16'hF0F0, 16'h3C3C, 10, 1'b0, 16'd0);

    // Back-to-back with cmd_valid held high and rsp_ready tied high.
    sel = 1'b0; ovr_en = 1'b0;
    wait_ready();
    op = 3'd0; a = 16'h7FFF; b = 16'h0001; e1 = alu_ref(3'd0, 16'h7FFF, 16'h0001);
    a2 = 16'h00FF; e2 = alu_ref(3'd3, a2, 16'hF000);
    rsp_ready = 1'b1; cv0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin op = 3'd3; a = a2; b = 16'hF000; end
      check("b2b_in1", 32'(s_in1), 32'(c == 1 || c == 7));
      check("b2b_ready", 32'(s_cr), 32'(c == 6 || c == 12));
      check("b2b_valid", 32'(s_rv), 32'(c == 5 || c == 11));
      if (c == 5)  check("b2b_data1", 32'(s_rd), 32'(e1));
      if (c == 11) check("b2b_data2", 32'(s_rd), 32'(e2));
      if (c == 7) begin
        check("b2b_drive2", 32'(s_bd), 32'(a2));
        cv0 = 1'b0;
      end
    end
    rsp_ready = 1'b0;

    // Reset asserted mid-operation during EXEC.
    sel = 1'b0;
    wait_ready();
    op = 3'd6; a = 16'h1111; b = 16'h2222; cv0 = 1'b1;
    step();
    cv0 = 1'b0;
    step();
    step();
    check("abort_in_exec", 32'(s_lat), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero("abort_async");
    @(negedge clk);
    check_zero("abort_held");
    rst = 1'b0;
    step();
    check("abort_ready", 32'(s_cr), 32'd1);
    check("abort_no_valid", 32'(s_rv), 32'd0);
    run_cmd(1'b0, 3'd6, 16'h1111, 16'h2222, 1, 1'b0, 16'd0);

    // Randomized commands against the reference model.
    for (int i = 0; i < 16; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), 1'b0, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
